// File: rtl/outpkt_pkg.sv
// Shared definitions for the outpkt_header framer: FSM state encoding,
// section lengths and header byte offsets. The PAD state only exists when
// OUTPKT_WORD_ALIGN_EN is defined.
package outpkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_HCSUM = 3'd2,
    ST_DATA  = 3'd3,
    ST_DCSUM = 3'd4
`ifdef OUTPKT_WORD_ALIGN_EN
    , ST_PAD = 3'd5
`endif
  } state_t;

  localparam int HDR_LEN  = 10;
  localparam int CSUM_LEN = 4;

  localparam int HDR_OFS_VERSION = 0;
  localparam int HDR_OFS_TYPE    = 1;
  localparam int HDR_OFS_LEN0    = 4;
  localparam int HDR_OFS_LEN1    = 5;
  localparam int HDR_OFS_LEN2    = 6;
  localparam int HDR_OFS_ID0     = 8;
  localparam int HDR_OFS_ID1     = 9;

  // Index of the top bit needed to hold values 0..value.
  function automatic int msb_of(input int value);
    return (value <= 1) ? 0 : $clog2(value + 1) - 1;
  endfunction

endpackage

// File: rtl/outpkt_header_if.sv
// Bundle of the descriptor, upstream data and output byte stream signals of
// outpkt_header. The slave modport is the framer; the master modport is the
// surrounding logic that issues descriptors, supplies data and sinks bytes.
interface outpkt_header_if #(
  parameter int PKT_TYPE_MSB = outpkt_pkg::msb_of(3)
);

  logic                  pkt_start;
  logic [PKT_TYPE_MSB:0] pkt_type;
  logic [15:0]           pkt_id;
  logic [23:0]           pkt_len;
  logic                  busy;
  logic                  err_start;
  logic [7:0]            din;
  logic                  din_valid;
  logic                  din_rd;
  logic [7:0]            dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  pkt_done;

  modport master (
    output pkt_start, pkt_type, pkt_id, pkt_len, din, din_valid, dout_ready,
    input  busy, err_start, din_rd, dout, dout_valid, pkt_done
  );

  modport slave (
    input  pkt_start, pkt_type, pkt_id, pkt_len, din, din_valid, dout_ready,
    output busy, err_start, din_rd, dout, dout_valid, pkt_done
  );

endinterface

// File: rtl/outpkt_checksum.sv
// Section checksum for outpkt_header. Bytes are packed little-endian into a
// 32-bit word; each completed word is added into the running sum. The
// presented checksum is ~(sum + partial word), so a short final word counts
// as zero-padded without needing an explicit flush.
module outpkt_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       add,
  input  logic [7:0] add_byte,
  input  logic       clear,
  input  logic [1:0] sel,
  output logic [7:0] csum_byte
);

  logic [31:0] sum;
  logic [31:0] partial;
  logic [1:0]  pos;
  logic [31:0] word_next;
  logic [31:0] csum;

  assign word_next = partial | ({24'd0, add_byte} << {pos, 3'b000});
  assign csum      = ~(sum + partial);

  // Assemble bytes into words and fold completed words into the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      partial <= '0;
      pos     <= '0;
    end else if (clear) begin
      sum     <= '0;
      partial <= '0;
      pos     <= '0;
    end else if (add) begin
      if (pos == 2'd3) begin
        sum     <= sum + word_next;
        partial <= '0;
      end else begin
        partial <= word_next;
      end
      pos <= pos + 2'd1;
    end
  end

  // Pick the requested checksum byte, least significant first.
  always_comb begin
    csum_byte = csum[7:0];
    case (sel)
      2'd0: csum_byte = csum[7:0];
      2'd1: csum_byte = csum[15:8];
      2'd2: csum_byte = csum[23:16];
      2'd3: csum_byte = csum[31:24];
      default: csum_byte = csum[7:0];
    endcase
  end

endmodule

// File: rtl/outpkt_header.sv
// Transmit framer: header, header checksum, payload, payload checksum.
// Optional feature macro OUTPKT_WORD_ALIGN_EN appends a 0x00 pad byte to
// packets with odd payload length so the stream stays 16-bit aligned.
// VERSION must be nonzero and PKT_MAX_LEN must lie in [65536, 2^24).
module outpkt_header
  import outpkt_pkg::*;
#(
  parameter int VERSION      = 2,
  parameter int PKT_MAX_LEN  = 65536,
  parameter int PKT_MAX_TYPE = 3,
  parameter int PKT_TYPE_MSB = msb_of(PKT_MAX_TYPE)
) (
  input logic             CLK,
  input logic             RST_N,
  outpkt_header_if.slave  bus
);

  state_t      state;
  logic [3:0]  idx;
  logic [23:0] dcnt;
  logic [7:0]  type_r;
  logic [15:0] id_r;
  logic [23:0] len_r;
  logic        busy_r;
  logic        err_start_r;
  logic [7:0]  dout_r;
  logic        dout_valid_r;
  logic        dout_last_r;

  logic [7:0]  next_byte;
  logic        have_byte;
  logic        last_byte;
  logic        load_en;
  logic        load;
  logic        transfer;
  logic        done;
  logic        start_seen;
  logic        bad_desc;
  logic        cs_add;
  logic        cs_clear;
  logic [7:0]  csum_byte;

  assign load_en    = !dout_valid_r || bus.dout_ready;
  assign load       = load_en && have_byte;
  assign transfer   = dout_valid_r && bus.dout_ready;
  assign done       = transfer && dout_last_r;
  assign start_seen = bus.pkt_start && !bus.busy && (state == ST_IDLE);
  assign bad_desc   = (bus.pkt_len == 24'd0)
                   || ({8'd0, bus.pkt_len} > 32'(PKT_MAX_LEN))
                   || (bus.pkt_type == '0)
                   || (32'(bus.pkt_type) > 32'(PKT_MAX_TYPE));

  assign cs_add   = load && ((state == ST_HDR) || (state == ST_DATA));
  assign cs_clear = load && ((state == ST_HCSUM) || (state == ST_DCSUM))
                 && (idx == 4'(CSUM_LEN - 1));

  assign bus.din_rd     = (state == ST_DATA) && bus.din_valid && load_en;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.pkt_done   = done;
  assign bus.busy       = busy_r && !done;
  assign bus.err_start  = err_start_r;

  outpkt_checksum u_checksum (
    .clk       (CLK),
    .rst_n     (RST_N),
    .add       (cs_add),
    .add_byte  (next_byte),
    .clear     (cs_clear),
    .sel       (idx[1:0]),
    .csum_byte (csum_byte)
  );

  // Choose the byte the current state wants to send and whether it ends the packet.
  always_comb begin
    next_byte = 8'h00;
    have_byte = 1'b0;
    last_byte = 1'b0;
    case (state)
      ST_HDR: begin
        have_byte = 1'b1;
        case (idx)
          4'(HDR_OFS_VERSION): next_byte = 8'(VERSION);
          4'(HDR_OFS_TYPE):    next_byte = type_r;
          4'(HDR_OFS_LEN0):    next_byte = len_r[7:0];
          4'(HDR_OFS_LEN1):    next_byte = len_r[15:8];
          4'(HDR_OFS_LEN2):    next_byte = len_r[23:16];
          4'(HDR_OFS_ID0):     next_byte = id_r[7:0];
          4'(HDR_OFS_ID1):     next_byte = id_r[15:8];
          default:             next_byte = 8'h00;
        endcase
      end
      ST_HCSUM: begin
        have_byte = 1'b1;
        next_byte = csum_byte;
      end
      ST_DATA: begin
        have_byte = bus.din_valid;
        next_byte = bus.din;
      end
      ST_DCSUM: begin
        have_byte = 1'b1;
        next_byte = csum_byte;
`ifdef OUTPKT_WORD_ALIGN_EN
        last_byte = (idx == 4'(CSUM_LEN - 1)) && !len_r[0];
`else
        last_byte = (idx == 4'(CSUM_LEN - 1));
`endif
      end
`ifdef OUTPKT_WORD_ALIGN_EN
      ST_PAD: begin
        have_byte = 1'b1;
        last_byte = 1'b1;
      end
`endif
      default: begin
        have_byte = 1'b0;
      end
    endcase
  end

  // Framer FSM together with the single registered output byte stage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      idx          <= '0;
      dcnt         <= '0;
      type_r       <= '0;
      id_r         <= '0;
      len_r        <= '0;
      busy_r       <= 1'b0;
      err_start_r  <= 1'b0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
    end else begin
      err_start_r <= start_seen && bad_desc;

      if (start_seen && !bad_desc) begin
        busy_r <= 1'b1;
      end else if (done) begin
        busy_r <= 1'b0;
      end

      if (load) begin
        dout_r       <= next_byte;
        dout_valid_r <= 1'b1;
        dout_last_r  <= last_byte;
      end else if (transfer) begin
        dout_valid_r <= 1'b0;
        dout_last_r  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start_seen && !bad_desc) begin
            type_r <= 8'(bus.pkt_type);
            id_r   <= bus.pkt_id;
            len_r  <= bus.pkt_len;
            idx    <= '0;
            state  <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (load) begin
            if (idx == 4'(HDR_LEN - 1)) begin
              idx   <= '0;
              state <= ST_HCSUM;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_HCSUM: begin
          if (load) begin
            if (idx == 4'(CSUM_LEN - 1)) begin
              idx   <= '0;
              dcnt  <= '0;
              state <= ST_DATA;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (load) begin
            if (dcnt == len_r - 24'd1) begin
              dcnt  <= '0;
              state <= ST_DCSUM;
            end else begin
              dcnt <= dcnt + 24'd1;
            end
          end
        end
        ST_DCSUM: begin
          if (load) begin
            if (idx == 4'(CSUM_LEN - 1)) begin
              idx <= '0;
`ifdef OUTPKT_WORD_ALIGN_EN
              state <= len_r[0] ? ST_PAD : ST_IDLE;
`else
              state <= ST_IDLE;
`endif
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
`ifdef OUTPKT_WORD_ALIGN_EN
        ST_PAD: begin
          if (load) begin
            state <= ST_IDLE;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_outpkt_header.sv
// Self-checking bench for outpkt_header. A packet-level model turns each
// accepted descriptor plus its payload into the exact expected byte list;
// a per-cycle monitor compares every output transfer against that list.
// Honours OUTPKT_WORD_ALIGN_EN for the trailing pad byte.
module tb_outpkt_header;
  import outpkt_pkg::*;

  localparam int VERSION      = 2;
  localparam int PKT_MAX_LEN  = 65536;
  localparam int PKT_MAX_TYPE = 3;
  localparam int PKT_TYPE_MSB = msb_of(PKT_MAX_TYPE);

  typedef logic [8:0] ent_t;
  typedef ent_t entq_t[$];

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  outpkt_header_if #(.PKT_TYPE_MSB(PKT_TYPE_MSB)) bus ();

  outpkt_header #(
    .VERSION      (VERSION),
    .PKT_MAX_LEN  (PKT_MAX_LEN),
    .PKT_MAX_TYPE (PKT_MAX_TYPE),
    .PKT_TYPE_MSB (PKT_TYPE_MSB)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int         checks     = 0;
  int         passes     = 0;
  ent_t       exp_q[$];
  logic [7:0] data_q[$];
  int         ready_pct  = 100;
  int         valid_pct  = 100;
  logic       consumed   = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dout  = 8'h00;
  int         out_count  = 0;
  int         done_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  // Inverted 32-bit sum of the section, byte k weighted by 256^(k mod 4).
  function automatic logic [31:0] sectionCsum(input logic [7:0] b[$]);
    logic [31:0] sum = 32'd0;
    for (int k = 0; k < b.size(); k++) sum = sum + (32'(b[k]) << (8 * (k % 4)));
    return ~sum;
  endfunction

  function automatic entq_t buildPacket(input int typ, input int id, input int len, input logic [7:0] data[$]);
    entq_t       pkt;
    logic [7:0]  hdr[$];
    logic [31:0] c;
    hdr = '{8'(VERSION), 8'(typ), 8'h00, 8'h00, 8'(len), 8'(len >> 8), 8'(len >> 16),
            8'h00, 8'(id), 8'(id >> 8)};
    foreach (hdr[k]) pkt.push_back({1'b0, hdr[k]});
    c = sectionCsum(hdr);
    for (int k = 0; k < 4; k++) pkt.push_back({1'b0, 8'(c >> (8 * k))});
    foreach (data[k]) pkt.push_back({1'b0, data[k]});
    c = sectionCsum(data);
    for (int k = 0; k < 4; k++) pkt.push_back({1'b0, 8'(c >> (8 * k))});
`ifdef OUTPKT_WORD_ALIGN_EN
    if (len % 2 == 1) pkt.push_back(9'h000);
`endif
    pkt[pkt.size() - 1][8] = 1'b1;
    return pkt;
  endfunction

  task automatic waitIdle();
    int n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 5000) begin
      @(posedge CLK); #2;
      n++;
    end
    if (n >= 5000) begin
      checks++;
      $display("[TB] FAIL wait_idle_timeout: got busy=%0d pending=%0d, want idle", bus.busy, exp_q.size());
    end
  endtask

  // Issue one descriptor; the bench decides acceptance from the legality rules.
  task automatic applyStimulus(input int typ, input int id, input int len, input logic [7:0] data[$]);
    bit    good;
    entq_t pkt;
    good = (len >= 1) && (len <= PKT_MAX_LEN) && (typ >= 1) && (typ <= PKT_MAX_TYPE);
    waitIdle();
    @(posedge CLK); #2;
    bus.pkt_start = 1'b1;
    bus.pkt_type  = (PKT_TYPE_MSB + 1)'(typ);
    bus.pkt_id    = 16'(id);
    bus.pkt_len   = 24'(len);
    if (good) begin
      pkt = buildPacket(typ, id, len, data);
      foreach (pkt[k]) exp_q.push_back(pkt[k]);
      foreach (data[k]) data_q.push_back(data[k]);
    end
    @(posedge CLK); #2;
    bus.pkt_start = 1'b0;
    checkOutput("err_start", bus.err_start, !good);
    checkOutput("busy_after_start", bus.busy, good);
    @(posedge CLK); #2;
    checkOutput("err_start_pulse_width", bus.err_start, 1'b0);
    if (!good) checkOutput("dout_valid_after_reject", bus.dout_valid, 1'b0);
  endtask

  // Output monitor: every transfer is compared with the model's next byte.
  initial begin
    ent_t e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        consumed   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (bus.din_rd) checkOutput("din_rd_without_valid", bus.din_valid, 1'b1);
        if (prev_stall) begin
          checkOutput("stall_valid", bus.dout_valid, 1'b1);
          checkOutput("stall_hold", bus.dout, prev_dout);
        end
        if (bus.dout_valid && bus.dout_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h, want no transfer", bus.dout);
          end else begin
            e = exp_q.pop_front();
            checkOutput("dout", bus.dout, e[7:0]);
            checkOutput("pkt_done", bus.pkt_done, e[8]);
          end
          out_count++;
          if (bus.pkt_done) done_count++;
        end else begin
          checkOutput("pkt_done_no_transfer", bus.pkt_done, 1'b0);
        end
        prev_stall = bus.dout_valid && !bus.dout_ready;
        prev_dout  = bus.dout;
        consumed   = bus.din_rd;
      end
    end
  end

  // Upstream source and sink back-pressure, randomised per cycle.
  initial begin
    bus.din_valid  = 1'b0;
    bus.din        = 8'h00;
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge CLK); #1;
      if (consumed && data_q.size() > 0) void'(data_q.pop_front());
      consumed       = 1'b0;
      bus.din_valid  = (data_q.size() > 0) && ($urandom_range(99) < valid_pct);
      bus.din        = bus.din_valid ? data_q[0] : 8'($urandom);
      bus.dout_ready = $urandom_range(99) < ready_pct;
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] t1[20];
    logic [7:0] d[$];
    entq_t      pkt;
    int         n1;
    int         n;

    bus.pkt_start = 1'b0;
    bus.pkt_type  = '0;
    bus.pkt_id    = '0;
    bus.pkt_len   = '0;

    repeat (3) @(posedge CLK);
    #2;
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_err_start", bus.err_start, 1'b0);
    checkOutput("reset_din_rd", bus.din_rd, 1'b0);
    checkOutput("reset_dout_valid", bus.dout_valid, 1'b0);
    checkOutput("reset_dout", bus.dout, 8'h00);
    checkOutput("reset_pkt_done", bus.pkt_done, 1'b0);
    #1 RST_N = 1'b1;

    // Case 1: hand-computed packet pins the model, then the DUT runs it.
    t1 = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12,
           8'hC8, 8'hEC, 8'hFF, 8'hFF, 8'hAB, 8'h54, 8'hFF, 8'hFF, 8'hFF, 8'h00};
`ifdef OUTPKT_WORD_ALIGN_EN
    n1 = 20;
`else
    n1 = 19;
`endif
    d = '{8'hAB};
    pkt = buildPacket(1, 16'h1234, 1, d);
    checkOutput("model_t1_len", pkt.size(), n1);
    for (int i = 0; i < n1; i++) checkOutput("model_t1_byte", pkt[i][7:0], t1[i]);
    out_count = 0; done_count = 0;
    applyStimulus(1, 16'h1234, 1, d);
    waitIdle();
    checkOutput("t1_out_count", out_count, n1);
    checkOutput("t1_done_count", done_count, 1);

    // Case 2: payload checksum literal, full speed.
    d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pkt = buildPacket(2, 16'h0042, 5, d);
    checkOutput("model_t2_dcsum0", pkt[19][7:0], 8'hF9);
    checkOutput("model_t2_dcsum1", pkt[20][7:0], 8'hFD);
    checkOutput("model_t2_dcsum2", pkt[21][7:0], 8'hFC);
    checkOutput("model_t2_dcsum3", pkt[22][7:0], 8'hFB);
    applyStimulus(2, 16'h0042, 5, d);
    waitIdle();

    // Case 3: same packet under back-pressure and source gaps.
    ready_pct = 50; valid_pct = 50;
    out_count = 0; done_count = 0;
    applyStimulus(2, 16'h0042, 5, d);
    waitIdle();
    checkOutput("t3_out_count", out_count, pkt.size());
    checkOutput("t3_done_count", done_count, 1);
    ready_pct = 100; valid_pct = 100;

    // Case 4: illegal descriptors are rejected and emit nothing.
    out_count = 0;
    d.delete();
    applyStimulus(1, 16'h0001, 0, d);
    applyStimulus(1, 16'h0002, PKT_MAX_LEN + 1, d);
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(0, 16'h0003, 4, d);
    repeat (4) @(posedge CLK);
    #2;
    checkOutput("t4_busy", bus.busy, 1'b0);
    checkOutput("t4_dout_valid", bus.dout_valid, 1'b0);
    checkOutput("t4_out_count", out_count, 0);

    // Case 5: a descriptor offered mid-packet is ignored.
    ready_pct = 70; valid_pct = 70;
    d.delete();
    for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
    applyStimulus(3, 16'h5555, 12, d);
    n = 0;
    while (data_q.size() > 8 && n < 2000) begin @(posedge CLK); #2; n++; end
    checkOutput("t5_reached_data", data_q.size() <= 8, 1'b1);
    bus.pkt_start = 1'b1; bus.pkt_id = 16'hBEEF; bus.pkt_type = 2'(1); bus.pkt_len = 24'd3;
    @(posedge CLK); #2;
    bus.pkt_start = 1'b0;
    @(posedge CLK); #2;
    checkOutput("t5_no_err", bus.err_start, 1'b0);
    waitIdle();
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("t5_no_second_packet", bus.dout_valid, 1'b0);
    ready_pct = 100; valid_pct = 100;

    // Case 6: asynchronous reset mid-payload, then a fresh packet.
    d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    applyStimulus(1, 16'h0808, 8, d);
    n = 0;
    while (data_q.size() > 5 && n < 2000) begin @(posedge CLK); #2; n++; end
    @(posedge CLK); #3;
    RST_N = 1'b0;
    #1;
    checkOutput("t6_async_dout_valid", bus.dout_valid, 1'b0);
    checkOutput("t6_async_busy", bus.busy, 1'b0);
    exp_q.delete();
    data_q.delete();
    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b1;
    out_count = 0; done_count = 0;
    d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    applyStimulus(2, 16'h0606, 6, d);
    waitIdle();
    checkOutput("t6_done_count", done_count, 1);

    // Randomised packets with random back-pressure.
    for (int p = 0; p < 10; p++) begin
      int len;
      ready_pct = $urandom_range(30, 100);
      valid_pct = $urandom_range(30, 100);
      len = $urandom_range(1, 40);
      d.delete();
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      applyStimulus($urandom_range(1, PKT_MAX_TYPE), $urandom_range(0, 65535), len, d);
    end
    waitIdle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/outpkt_header.md
Name: outpkt_header

Overview:
Transmit-side framer for the FPGA-to-host packet stream. It takes a packet descriptor (type, id, length), emits the 10-byte header and its 4-byte checksum, and passes exactly `length` data bytes from an upstream source. It then emits the 4-byte data checksum. It sits between the application output buffers and the byte-wide output FIFO feeding the USB interface.

Parameters:
- VERSION, 2: value of header byte 0; must be nonzero.
- PKT_MAX_LEN, 65536: maximum accepted data length in bytes; must be ≥ 65536 and < 2^24.
- PKT_MAX_TYPE, 3: highest legal packet type.
- PKT_TYPE_MSB, `MSB(PKT_MAX_TYPE): MSB of the pkt_type port.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- pkt_start  in  1  descriptor valid; sampled only while busy=0.
- pkt_type  in  PKT_TYPE_MSB+1  packet type.
- pkt_id  in  16  packet id.
- pkt_len  in  24  data length in bytes; excludes header and checksums.
- busy  out  1  packet in progress.
- err_start  out  1  one-cycle pulse when a descriptor is rejected.
- din  in  8  upstream data byte.
- din_valid  in  1  din holds a byte.
- din_rd  out  1  din consumed this cycle.
- dout  out  8  output byte.
- dout_valid  out  1  dout holds a byte.
- dout_ready  in  1  sink accepts; a transfer occurs when dout_valid & dout_ready.
- pkt_done  out  1  one-cycle pulse on the transfer of the final byte of the packet.

Behaviour:
- Reset values: busy=0, err_start=0, din_rd=0, dout_valid=0, dout=0, pkt_done=0. State is IDLE, checksum accumulators are 0, counters are 0.
- Output stage: one registered byte. It loads when (dout_valid=0 | dout_ready=1) and the FSM has a byte to send.
  - Full throughput is one byte/cycle.
  - While dout_ready=0 with dout_valid=1, dout holds stable.
- Descriptor acceptance, in IDLE only:
  - On pkt_start, reject if pkt_len==0, pkt_len>PKT_MAX_LEN, pkt_type==0, or pkt_type>PKT_MAX_TYPE. A rejection gives err_start=1 for one cycle, the FSM stays in IDLE, and nothing is emitted.
  - Otherwise, latch type, id and len, set busy=1 on the next cycle, and go to HDR.
  - pkt_start while busy=1 is ignored.
- FSM states: IDLE, HDR, HCSUM, DATA, DCSUM, PAD (PAD exists only with the optional feature).
- HDR emits 10 bytes in order: VERSION, type, 0x00, 0x00, len[7:0], len[15:8], len[23:16], 0x00, id[7:0], id[15:8]. Then go to HCSUM.
- HCSUM emits 4 bytes, then goes to DATA.
- DATA:
  - din_rd = din_valid & output-load-enable.
  - Each din_rd moves din into dout.
  - No bubble byte is inserted when din_valid=0.
  - After len bytes have been read, go to DCSUM.
- DCSUM emits 4 bytes. Then go to IDLE, or to PAD if that feature is enabled.
- pkt_done pulses on the transfer of the last DCSUM (or PAD) byte. busy drops the same cycle.
- Checksum rules:
  - Sections are HDR and DATA. Each section's bytes are packed little-endian into 32-bit words: byte k of the section goes to bits 8*(k%4)+7 : 8*(k%4).
  - A partial final word is zero-padded.
  - Words are summed mod 2^32. The checksum is the bitwise inverse of the sum.
  - The checksum is sent little-endian, least significant byte first.
  - The accumulator clears after each checksum is sent, so each checksum covers only its own section.
- The data byte counter is 24 bits and compares against latched len-1. Wrap is impossible because len ≤ PKT_MAX_LEN.
- Reset mid-packet: the output truncates immediately, dout_valid=0, and nothing is resumed.

Optional Feature:
OUTPKT_WORD_ALIGN_EN.
- Defined: if the total packet byte count (len+18) is odd, i.e. len is odd, one 0x00 byte (state PAD) follows DCSUM. This keeps the stream aligned to 16-bit words. The receiver skips 0x00 bytes while waiting for a version byte.
- Undefined: the PAD state and logic are absent, and packets end at DCSUM.

Decomposition:
- Package outpkt_pkg:
  - state encoding constants.
  - header length (10) and checksum length (4).
  - header byte offsets.
- Sub-module outpkt_checksum holds the word assembly, the 32-bit accumulator, byte-select and clear, and presents ~(sum+partial) plus a byte-indexed read.

Test Plan:
1. VERSION=2, type=1, id=0x1234, len=1, data 0xAB, dout_ready=1 → bytes 02 01 00 00 01 00 00 00 34 12 C8 EC FF FF AB 54 FF FF FF, 19 bytes. With OUTPKT_WORD_ALIGN_EN, a trailing 00 makes 20 bytes. pkt_done pulses on the last byte.
2. len=5, data 01 02 03 04 05 → DCSUM bytes F9 FD FC FB.
3. Repeat case 2 with dout_ready randomly low (50%) and din_valid gaps → identical byte sequence, dout stable while stalled, din_rd never asserted with din_valid=0.
4. pkt_start with len=0, then with len=PKT_MAX_LEN+1, then with type=0 → err_start pulses once each, dout_valid stays 0, busy stays 0.
5. pkt_start asserted during DATA with a different id → ignored; the current packet completes unchanged.
6. RST_N low during DATA at byte 3 of len=8 → dout_valid=0 and busy=0 asynchronously. A following valid descriptor produces a correct, fresh packet with checksums starting from 0.
